// File: rtl/cpu_bram_pkg.sv
// cpu_bram_pkg
//   Shared definitions for the cpu_bram single-port block RAM.
//   - bram_aw(size): number of word-index bits for a given depth
//     ($clog2 with a minimum of 1 so a 1-word RAM still has an index bit).
//   - CPU_BRAM_LATENCY: request-to-completion latency in cycles
//     (2 when CPU_BRAM_OUTREG_EN is defined, otherwise 1).
//   - bram_op_e: per-edge access classification used by the handshake logic.
package cpu_bram_pkg;

   function automatic int unsigned bram_aw(input int unsigned size);
      return (size < 2) ? 1 : $clog2(size);
   endfunction

`ifdef CPU_BRAM_OUTREG_EN
   localparam int unsigned CPU_BRAM_LATENCY = 2;
`else
   localparam int unsigned CPU_BRAM_LATENCY = 1;
`endif

   typedef enum logic [2:0] {
      OP_IDLE,        // no request on this edge
      OP_WRITE,       // in-range write
      OP_WRITE_DROP,  // write past the last word (non power-of-2 depth)
      OP_READ,        // in-range read
      OP_READ_ZERO    // read past the last word, returns zero
   } bram_op_e;

endpackage

// File: rtl/cpu_bram_array.sv
// cpu_bram_array
//   Raw storage for cpu_bram: one write port and one registered read port
//   sharing a single index. No reset on the array or its read register so
//   synthesis can map it onto block RAM. Contents power up undefined.
// Ports
//   i_clock  in   1      clock, rising edge
//   i_write  in   1      write enable (already range-qualified)
//   i_read   in   1      read enable (already range-qualified)
//   i_index  in   AW     word index
//   i_wdata  in   WIDTH  write data
//   o_rdata  out  WIDTH  read data, updated only on read edges
module cpu_bram_array #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SIZE  = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic             i_clock,
   input  logic             i_write,
   input  logic             i_read,
   input  logic [AW-1:0]    i_index,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem [SIZE];

   always_ff @(posedge i_clock) begin
      if (i_write) begin
         mem[i_index] <= i_wdata;
      end
      if (i_read) begin
         o_rdata <= mem[i_index];
      end
   end

endmodule

// File: rtl/cpu_bram.sv
// cpu_bram
//   Single-port synchronous block RAM with a request/ready handshake.
//   One access per cycle, no back-pressure. Read data is registered and
//   arrives one cycle after the request (two with CPU_BRAM_OUTREG_EN).
//   Configuration macro: CPU_BRAM_OUTREG_EN adds one output register stage
//   after the array (all outputs delayed one more cycle, also reset).
// Parameters
//   WIDTH     data word width
//   SIZE      depth in words
//   ADDR_LSH  right shift from byte address to word index
// Ports
//   i_clock    in   1      clock, rising edge
//   i_reset    in   1      asynchronous active-high reset (outputs only)
//   i_request  in   1      access request
//   i_rw       in   1      0 = read, 1 = write
//   i_address  in   32     address; index = (i_address >> ADDR_LSH)[AW-1:0]
//   i_wdata    in   WIDTH  write data
//   o_rdata    out  WIDTH  read data, holds last read value
//   o_ready    out  1      access completed
//   o_valid    out  1      o_rdata carries data of the completed read
module cpu_bram
   import cpu_bram_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned SIZE     = 1024,
   parameter int unsigned ADDR_LSH = 2
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_request,
   input  logic             i_rw,
   input  logic [31:0]      i_address,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_ready,
   output logic             o_valid
);

   localparam int unsigned AW = bram_aw(SIZE);

   logic [31:0]      word_addr;
   logic [AW-1:0]    index;
   logic             in_range;
   logic             unused_addr_hi;
   bram_op_e         op;

   logic             arr_write;
   logic             arr_read;
   logic [WIDTH-1:0] arr_rdata;

   logic             s1_ready;
   logic             s1_valid;
   logic             s1_sel;
   logic [WIDTH-1:0] s1_rdata;

   // Address bits above the index are ignored, giving wrap-around.
   assign word_addr      = i_address >> ADDR_LSH;
   assign index          = word_addr[AW-1:0];
   assign unused_addr_hi = ^word_addr[31:AW];
   assign in_range       = (32'(index) < SIZE);

   always_comb begin
      op = OP_IDLE;
      if (i_request) begin
         if (i_rw) begin
            op = in_range ? OP_WRITE : OP_WRITE_DROP;
         end else begin
            op = in_range ? OP_READ : OP_READ_ZERO;
         end
      end
   end

   assign arr_write = (op == OP_WRITE);
   assign arr_read  = (op == OP_READ);

   cpu_bram_array #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .AW    (AW)
   ) u_array (
      .i_clock (i_clock),
      .i_write (arr_write),
      .i_read  (arr_read),
      .i_index (index),
      .i_wdata (i_wdata),
      .o_rdata (arr_rdata)
   );

   // The array read register has no reset, so s1_sel gates it: zero after
   // reset and after an out-of-range read, array data after an in-range
   // read, unchanged on writes and idle edges (hold behaviour).
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         s1_ready <= 1'b0;
         s1_valid <= 1'b0;
         s1_sel   <= 1'b0;
      end else begin
         s1_ready <= (op != OP_IDLE);
         s1_valid <= (op == OP_READ) || (op == OP_READ_ZERO);
         if (op == OP_READ) begin
            s1_sel <= 1'b1;
         end else if (op == OP_READ_ZERO) begin
            s1_sel <= 1'b0;
         end
      end
   end

   assign s1_rdata = s1_sel ? arr_rdata : '0;

`ifdef CPU_BRAM_OUTREG_EN
   logic             s2_ready;
   logic             s2_valid;
   logic [WIDTH-1:0] s2_rdata;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         s2_ready <= 1'b0;
         s2_valid <= 1'b0;
         s2_rdata <= '0;
      end else begin
         s2_ready <= s1_ready;
         s2_valid <= s1_valid;
         s2_rdata <= s1_rdata;
      end
   end

   assign o_ready = s2_ready;
   assign o_valid = s2_valid;
   assign o_rdata = s2_rdata;
`else
   assign o_ready = s1_ready;
   assign o_valid = s1_valid;
   assign o_rdata = s1_rdata;
`endif

endmodule

// File: tb/tb_cpu_bram.sv
// tb_cpu_bram
//   Self-checking bench for cpu_bram. Two instances: a default 32x1024
//   byte-addressed RAM and an 8x12 word-addressed RAM (non power-of-2 depth,
//   wrap-around and out-of-range behaviour). Directed table, hand-written
//   sequences and a randomized run against a behavioural model.
module tb_cpu_bram;

`ifdef CPU_BRAM_OUTREG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic        clk;
   logic        rst;

   logic        m_req, m_rw;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_ready, m_valid;

   logic        s_req, s_rw;
   logic [31:0] s_addr;
   logic [7:0]  s_wdata, s_rdata;
   logic        s_ready, s_valid;

   cpu_bram #(.WIDTH(32), .SIZE(1024), .ADDR_LSH(2)) u_main (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_request (m_req),
      .i_rw      (m_rw),
      .i_address (m_addr),
      .i_wdata   (m_wdata),
      .o_rdata   (m_rdata),
      .o_ready   (m_ready),
      .o_valid   (m_valid)
   );

   cpu_bram #(.WIDTH(8), .SIZE(12), .ADDR_LSH(0)) u_small (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_request (s_req),
      .i_rw      (s_rw),
      .i_address (s_addr),
      .i_wdata   (s_wdata),
      .o_rdata   (s_rdata),
      .o_ready   (s_ready),
      .o_valid   (s_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          ready;
      bit          valid;
      logic [31:0] rdata;
   } out_t;

   out_t        hist [2][2];   // [instance][age], age 0 = latest edge
   logic [31:0] last_rd [2];
   logic [31:0] mem_m [int unsigned];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         last_rd[i] = 32'h0;
         for (int a = 0; a < 2; a++) hist[i][a] = '{1'b0, 1'b0, 32'h0};
      end
   endfunction

   function automatic void model_edge(input int unsigned inst, input bit req, input bit rw,
                                      input logic [31:0] addr, input logic [31:0] wd);
      int unsigned size, lsh, aw, idx, key;
      logic [31:0] mask;
      out_t o;
      size = (inst == 0) ? 1024 : 12;
      lsh  = (inst == 0) ? 2 : 0;
      aw   = (inst == 0) ? 10 : 4;
      mask = (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      idx  = (addr >> lsh) % (32'd1 << aw);
      key  = (inst << 20) | idx;
      if (!req) begin
         o = '{1'b0, 1'b0, last_rd[inst]};
      end else if (rw) begin
         if (idx < size) mem_m[key] = wd & mask;
         o = '{1'b1, 1'b0, last_rd[inst]};
      end else begin
         if (idx >= size)          last_rd[inst] = 32'h0;
         else if (mem_m.exists(key)) last_rd[inst] = mem_m[key];
         else                      last_rd[inst] = 'x;
         o = '{1'b1, 1'b1, last_rd[inst]};
      end
      hist[inst][1] = hist[inst][0];
      hist[inst][0] = o;
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         model_edge(0, m_req, m_rw, m_addr, m_wdata);
         model_edge(1, s_req, s_rw, s_addr, {24'h0, s_wdata});
      end
      #1;
   endtask

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic void check_out(input string name, input int unsigned inst,
                                     input bit r, input bit v, input logic [31:0] d);
      if (inst == 0) begin
         check({name, ".ready"}, {31'h0, m_ready}, {31'h0, r});
         check({name, ".valid"}, {31'h0, m_valid}, {31'h0, v});
         check({name, ".rdata"}, m_rdata, d);
      end else begin
         check({name, ".ready"}, {31'h0, s_ready}, {31'h0, r});
         check({name, ".valid"}, {31'h0, s_valid}, {31'h0, v});
         check({name, ".rdata"}, {24'h0, s_rdata}, d);
      end
   endfunction

   function automatic void check_model(input string name);
      check_out({name, ".main"}, 0, hist[0][LAT-1].ready, hist[0][LAT-1].valid, hist[0][LAT-1].rdata);
      check_out({name, ".small"}, 1, hist[1][LAT-1].ready, hist[1][LAT-1].valid, hist[1][LAT-1].rdata);
   endfunction

   // One small-instance access followed by enough idle edges for it to appear.
   task automatic small_op(input bit rw, input logic [31:0] addr, input logic [7:0] wd);
      s_req = 1'b1; s_rw = rw; s_addr = addr; s_wdata = wd;
      cycle();
      s_req = 1'b0;
      for (int unsigned i = 1; i < LAT; i++) cycle();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          req;
      bit          rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          er;
      bit          ev;
      logic [31:0] ed;
   } vec_t;

   function automatic vec_t mk(input bit req, input bit rw, input logic [31:0] addr,
                               input logic [31:0] wd, input bit er, input bit ev,
                               input logic [31:0] ed);
      vec_t t;
      t = '{req, rw, addr, wd, er, ev, ed};
      return t;
   endfunction

   localparam int NVEC = 9;
   vec_t tbl [NVEC];

   initial begin
      tbl[0] = mk(1, 1, 32'h10,   32'hDEAD_BEEF, 1, 0, 32'h0);
      tbl[1] = mk(1, 0, 32'h10,   32'h0,         1, 1, 32'hDEAD_BEEF);
      tbl[2] = mk(1, 1, 32'h14,   32'h1,         1, 0, 32'hDEAD_BEEF);
      tbl[3] = mk(1, 1, 32'h14,   32'h2,         1, 0, 32'hDEAD_BEEF);
      tbl[4] = mk(1, 0, 32'h14,   32'h0,         1, 1, 32'h2);
      tbl[5] = mk(0, 0, 32'h0,    32'h0,         0, 0, 32'h2);
      tbl[6] = mk(0, 0, 32'h0,    32'h0,         0, 0, 32'h2);
      tbl[7] = mk(0, 0, 32'h0,    32'h0,         0, 0, 32'h2);
      tbl[8] = mk(1, 0, 32'h1010, 32'h0,         1, 1, 32'hDEAD_BEEF);

      m_req = 0; m_rw = 0; m_addr = 0; m_wdata = 0;
      s_req = 0; s_rw = 0; s_addr = 0; s_wdata = 0;
      rst = 1'b1;
      model_reset();
      repeat (2) cycle();
      check_out("reset_main", 0, 0, 0, 32'h0);
      check_out("reset_small", 1, 0, 0, 32'h0);
      rst = 1'b0;

      // Directed table on the main instance.
      for (int k = 0; k < NVEC + int'(LAT) - 1; k++) begin
         if (k < NVEC) begin
            m_req = tbl[k].req; m_rw = tbl[k].rw; m_addr = tbl[k].addr; m_wdata = tbl[k].wdata;
         end else begin
            m_req = 1'b0;
         end
         cycle();
         if (k >= int'(LAT) - 1) begin
            int j;
            j = k - int'(LAT) + 1;
            check_out($sformatf("vec%0d", j), 0, tbl[j].er, tbl[j].ev, tbl[j].ed);
         end
      end

      // Streaming: 16 back-to-back writes then 16 back-to-back reads.
      for (int k = 0; k < 16; k++) begin
         m_req = 1'b1; m_rw = 1'b1; m_addr = 32'(k * 4); m_wdata = 32'(k);
         cycle();
         if (k >= int'(LAT) - 1) check_out($sformatf("stream_wr%0d", k), 0, 1, 0, 32'hDEAD_BEEF);
      end
      for (int k = 0; k < 16 + int'(LAT) - 1; k++) begin
         if (k < 16) begin
            m_req = 1'b1; m_rw = 1'b0; m_addr = 32'(k * 4);
         end else begin
            m_req = 1'b0;
         end
         cycle();
         if (k >= int'(LAT) - 1)
            check_out($sformatf("stream_rd%0d", k - int'(LAT) + 1), 0, 1, 1, 32'(k - int'(LAT) + 1));
      end
      m_req = 1'b0;

      // Small instance: wrap-around and out-of-range index.
      small_op(1, 32'd3, 8'hA5);
      check_out("small_wr3", 1, 1, 0, 32'h0);
      small_op(0, 32'd19, 8'h00);
      check_out("small_wrap_rd19", 1, 1, 1, 32'hA5);
      small_op(1, 32'd13, 8'h77);
      check_out("small_wr_oor", 1, 1, 0, 32'hA5);
      small_op(0, 32'd13, 8'h00);
      check_out("small_rd_oor", 1, 1, 1, 32'h0);
      small_op(0, 32'd3, 8'h00);
      check_out("small_rd3", 1, 1, 1, 32'hA5);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_out($sformatf("small_idle%0d", k), 1, 0, 0, 32'hA5);
      end

      // Prefill so random reads never hit unwritten words.
      for (int k = 0; k < 32; k++) begin
         m_req = 1'b1; m_rw = 1'b1; m_addr = 32'(k * 4); m_wdata = $urandom;
         s_req = 1'b1; s_rw = 1'b1; s_addr = 32'(k % 16); s_wdata = 8'($urandom);
         cycle();
         check_model("prefill");
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         m_req   = ($urandom_range(3) != 0);
         m_rw    = $urandom_range(1) == 1;
         m_addr  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(31)) << 2);
         m_wdata = $urandom;
         s_req   = ($urandom_range(3) != 0);
         s_rw    = $urandom_range(1) == 1;
         s_addr  = $urandom;
         s_wdata = 8'($urandom);
         cycle();
         check_model($sformatf("rand%0d", k));
      end

      // Asynchronous reset mid-cycle, then release while requests continue.
      m_req = 1'b1; m_rw = 1'b0; m_addr = 32'h0;
      s_req = 1'b1; s_rw = 1'b0; s_addr = 32'd3;
      for (int unsigned i = 0; i < LAT; i++) cycle();
      check_model("pre_reset");
      #3;
      rst = 1'b1;
      #1;
      check_out("async_reset_main", 0, 0, 0, 32'h0);
      check_out("async_reset_small", 1, 0, 0, 32'h0);
      model_reset();
      cycle();
      check_model("in_reset");
      #3;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_model($sformatf("post_reset%0d", k));
      end
      m_req = 1'b0; s_req = 1'b0;
      cycle();
      check_model("final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
